// File: rtl/dmem_pkg.sv
// Shared size encodings, byte-count helper and default data width for the dual-port data memory.
// Purely declarative: no logic, no latency, no flow control.
package dmem_pkg;

    localparam int D_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    function automatic logic [2:0] size_bytes(input size_e sz);
        case (sz)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Per-slot access decode: legality, byte-lane enables and load extension of raw lane data.
// Combinational (0 cycles); never stalls, no backpressure.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_raw,
    output logic        o_legal,
    output logic [3:0]  o_be,
    output logic [31:0] o_ext
);

    size_e sz;
    assign sz = size_e'(i_size);

    // Legality and lane enables stay independent of i_raw so the bypass read path cannot form a loop.
    always_comb begin
        o_legal = 1'b0;
        o_be    = 4'b0000;
        case (sz)
            SZ_BYTE: o_legal = 1'b1;
            SZ_HALF: o_legal = ~i_addr_lo[0];
            SZ_WORD: o_legal = (i_addr_lo == 2'b00);
            default: o_legal = 1'b0;
        endcase
        if (o_legal) begin
            o_be = 4'((5'd1 << size_bytes(sz)) - 5'd1);
        end
    end

    always_comb begin
        o_ext = 32'h0;
        case (sz)
            SZ_BYTE: o_ext = {{24{i_signed & i_raw[7]}}, i_raw[7:0]};
            SZ_HALF: o_ext = {{16{i_signed & i_raw[15]}}, i_raw[15:0]};
            SZ_WORD: o_ext = i_raw;
            default: o_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_dual_port_bytelane.sv
// Two-slot byte-addressed data memory; loads return 1 cycle after request, no stalls/backpressure.
// Slot 2 wins overlapping store bytes; `DMEM_BYPASS_EN makes loads see same-cycle stores.
module dmem_dual_port_bytelane
    import dmem_pkg::*;
#(
    parameter int D_WIDTH     = D_WIDTH_DEF,
    parameter int DEPTH_BYTES = 256,
    parameter int A_WIDTH     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_Req1,
    input  logic               i_Req2,
    input  logic               i_WE1,
    input  logic               i_WE2,
    input  logic [A_WIDTH-1:0] i_Address1,
    input  logic [A_WIDTH-1:0] i_Address2,
    input  logic [1:0]         i_Size1,
    input  logic [1:0]         i_Size2,
    input  logic               i_Signed1,
    input  logic               i_Signed2,
    input  logic [D_WIDTH-1:0] i_WriteData1,
    input  logic [D_WIDTH-1:0] i_WriteData2,
    output logic [D_WIDTH-1:0] o_RD1,
    output logic [D_WIDTH-1:0] o_RD2,
    output logic               o_Valid1,
    output logic               o_Valid2,
    output logic               o_Fault1,
    output logic               o_Fault2
);

    localparam int IW = $clog2(DEPTH_BYTES);

    logic [IW-1:0]      idx1, idx2;
    logic [7:0]         mem_q [DEPTH_BYTES];
    logic [7:0]         mem_d [DEPTH_BYTES];
    logic [31:0]        raw1, raw2, ext1, ext2;
    logic [3:0]         be1, be2;
    logic               legal1, legal2, wr1, wr2;
    logic [D_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic               valid1_q, valid1_d, valid2_q, valid2_d;
    logic               fault1_q, fault1_d, fault2_q, fault2_d;
    logic               unused_addr_hi;

    // Upper address bits wrap away by design.
    assign unused_addr_hi = ^{i_Address1[A_WIDTH-1:IW], i_Address2[A_WIDTH-1:IW]};

    assign idx1 = i_Address1[IW-1:0];
    assign idx2 = i_Address2[IW-1:0];
    assign wr1  = i_Req1 & i_WE1 & legal1;
    assign wr2  = i_Req2 & i_WE2 & legal2;

    dmem_lane_fmt u_fmt1 (
        .i_addr_lo (idx1[1:0]),
        .i_size    (i_Size1),
        .i_signed  (i_Signed1),
        .i_raw     (raw1),
        .o_legal   (legal1),
        .o_be      (be1),
        .o_ext     (ext1)
    );

    dmem_lane_fmt u_fmt2 (
        .i_addr_lo (idx2[1:0]),
        .i_size    (i_Size2),
        .i_signed  (i_Signed2),
        .i_raw     (raw2),
        .o_legal   (legal2),
        .o_be      (be2),
        .o_ext     (ext2)
    );

    // Slot 2 is applied last so it owns any byte both slots store.
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < 4; k++) begin
            if (wr1 && be1[k]) mem_d[idx1 + IW'(k)] = i_WriteData1[8*k +: 8];
        end
        for (int k = 0; k < 4; k++) begin
            if (wr2 && be2[k]) mem_d[idx2 + IW'(k)] = i_WriteData2[8*k +: 8];
        end
    end

    always_comb begin
        raw1 = 32'h0;
        raw2 = 32'h0;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_BYPASS_EN
            raw1[8*k +: 8] = mem_d[idx1 + IW'(k)];
            raw2[8*k +: 8] = mem_d[idx2 + IW'(k)];
`else
            raw1[8*k +: 8] = mem_q[idx1 + IW'(k)];
            raw2[8*k +: 8] = mem_q[idx2 + IW'(k)];
`endif
        end
    end

    // Stores and faults return zero data; an idle slot keeps its last load result.
    always_comb begin
        valid1_d = i_Req1;
        valid2_d = i_Req2;
        fault1_d = i_Req1 & ~legal1;
        fault2_d = i_Req2 & ~legal2;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        if (i_Req1) rd1_d = (legal1 && !i_WE1) ? ext1 : '0;
        if (i_Req2) rd2_d = (legal2 && !i_WE2) ? ext2 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_BYTES; i++) mem_q[i] <= 8'h00;
            rd1_q    <= '0;
            rd2_q    <= '0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            fault1_q <= 1'b0;
            fault2_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            valid1_q <= valid1_d;
            valid2_q <= valid2_d;
            fault1_q <= fault1_d;
            fault2_q <= fault2_d;
        end
    end

    assign o_RD1    = rd1_q;
    assign o_RD2    = rd2_q;
    assign o_Valid1 = valid1_q;
    assign o_Valid2 = valid2_q;
    assign o_Fault1 = fault1_q;
    assign o_Fault2 = fault2_q;

endmodule

// File: tb/tb_dmem_dual_port_bytelane.sv
// Directed bench for dmem_dual_port_bytelane with hand-computed expectations.
module tb_dmem_dual_port_bytelane;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_Req1, i_Req2, i_WE1, i_WE2, i_Signed1, i_Signed2;
    logic [31:0] i_Address1, i_Address2, i_WriteData1, i_WriteData2;
    logic [1:0]  i_Size1, i_Size2;
    logic [31:0] o_RD1, o_RD2;
    logic        o_Valid1, o_Valid2, o_Fault1, o_Fault2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_dual_port_bytelane #(.D_WIDTH(32), .DEPTH_BYTES(DEPTH), .A_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_Req1(i_Req1), .i_Req2(i_Req2), .i_WE1(i_WE1), .i_WE2(i_WE2),
        .i_Address1(i_Address1), .i_Address2(i_Address2),
        .i_Size1(i_Size1), .i_Size2(i_Size2),
        .i_Signed1(i_Signed1), .i_Signed2(i_Signed2),
        .i_WriteData1(i_WriteData1), .i_WriteData2(i_WriteData2),
        .o_RD1(o_RD1), .o_RD2(o_RD2), .o_Valid1(o_Valid1), .o_Valid2(o_Valid2),
        .o_Fault1(o_Fault1), .o_Fault2(o_Fault2)
    );

    task automatic idle();
        i_Req1 = 1'b0; i_Req2 = 1'b0; i_WE1 = 1'b0; i_WE2 = 1'b0;
    endtask

    task automatic drive1(input logic we, input logic [31:0] a, input logic [1:0] sz,
                          input logic sg, input logic [31:0] wd);
        i_Req1 = 1'b1; i_WE1 = we; i_Address1 = a; i_Size1 = sz; i_Signed1 = sg; i_WriteData1 = wd;
    endtask

    task automatic drive2(input logic we, input logic [31:0] a, input logic [1:0] sz,
                          input logic sg, input logic [31:0] wd);
        i_Req2 = 1'b1; i_WE2 = we; i_Address2 = a; i_Size2 = sz; i_Signed2 = sg; i_WriteData2 = wd;
    endtask

    // Present the driven request on the next edge, then sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        #12;
        checks++; if (o_Valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b expected 0", o_Valid1); end
        checks++; if (o_Fault1 !== 1'b0) begin errors++; $display("FAIL reset_fault1: got %b expected 0", o_Fault1); end
        checks++; if (o_RD1 !== 32'h0) begin errors++; $display("FAIL reset_rd1: got %h expected 00000000", o_RD1); end
        checks++; if (o_Valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid2: got %b expected 0", o_Valid2); end
        rst_n = 1'b1;
        drive1(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        step();
        checks++; if (o_RD1 !== 32'h0) begin errors++; $display("FAIL first_load_rd1: got %h expected 00000000", o_RD1); end
        checks++; if (o_Valid1 !== 1'b1) begin errors++; $display("FAIL first_load_valid1: got %b expected 1", o_Valid1); end
        checks++; if (o_Fault1 !== 1'b0) begin errors++; $display("FAIL first_load_fault1: got %b expected 0", o_Fault1); end
    endtask

    task automatic test_load_ext();
        drive1(1'b1, 32'h20, 2'b10, 1'b0, 32'h8899AABB);
        step();
        checks++; if (o_Valid1 !== 1'b1 || o_Fault1 !== 1'b0) begin errors++; $display("FAIL store_resp: got v=%b f=%b expected v=1 f=0", o_Valid1, o_Fault1); end
        checks++; if (o_RD1 !== 32'h0) begin errors++; $display("FAIL store_rd1: got %h expected 00000000", o_RD1); end
        drive2(1'b0, 32'h21, 2'b00, 1'b1, 32'h0);
        drive1(1'b0, 32'h22, 2'b01, 1'b0, 32'h0);
        step();
        checks++; if (o_RD2 !== 32'hFFFFFFAA) begin errors++; $display("FAIL byte_signed: got %h expected ffffffaa", o_RD2); end
        checks++; if (o_RD1 !== 32'h00008899) begin errors++; $display("FAIL half_unsigned: got %h expected 00008899", o_RD1); end
        drive2(1'b0, 32'h21, 2'b00, 1'b0, 32'h0);
        drive1(1'b0, 32'h22, 2'b01, 1'b1, 32'h0);
        step();
        checks++; if (o_RD2 !== 32'h000000AA) begin errors++; $display("FAIL byte_unsigned: got %h expected 000000aa", o_RD2); end
        checks++; if (o_RD1 !== 32'hFFFF8899) begin errors++; $display("FAIL half_signed: got %h expected ffff8899", o_RD1); end
    endtask

    task automatic test_collision();
        drive1(1'b1, 32'h40, 2'b10, 1'b0, 32'h11223344);
        drive2(1'b1, 32'h41, 2'b00, 1'b0, 32'h000000EE);
        step();
        checks++; if (o_Valid2 !== 1'b1 || o_Fault2 !== 1'b0) begin errors++; $display("FAIL coll_resp2: got v=%b f=%b expected v=1 f=0", o_Valid2, o_Fault2); end
        drive1(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
        drive2(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
        step();
        checks++; if (o_RD1 !== 32'h1122EE44) begin errors++; $display("FAIL coll_rd1: got %h expected 1122ee44", o_RD1); end
        checks++; if (o_RD2 !== 32'h1122EE44) begin errors++; $display("FAIL same_addr_rd2: got %h expected 1122ee44", o_RD2); end
        drive1(1'b1, 32'h60, 2'b00, 1'b0, 32'h00000077);
        drive2(1'b1, 32'h62, 2'b01, 1'b0, 32'h1234BEEF);
        step();
        drive1(1'b0, 32'h60, 2'b10, 1'b0, 32'h0);
        step();
        checks++; if (o_RD1 !== 32'hBEEF0077) begin errors++; $display("FAIL disjoint_stores: got %h expected beef0077", o_RD1); end
    endtask

    task automatic test_faults();
        drive1(1'b1, 32'h30, 2'b10, 1'b0, 32'h01020304);
        step();
        drive1(1'b0, 32'h30, 2'b10, 1'b0, 32'h0);
        drive2(1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
        step();
        checks++; if (o_RD2 !== 32'h8899AABB) begin errors++; $display("FAIL pre_fault_rd2: got %h expected 8899aabb", o_RD2); end
        drive1(1'b1, 32'h31, 2'b01, 1'b0, 32'h0000AAAA);
        drive2(1'b0, 32'h42, 2'b11, 1'b0, 32'h0);
        step();
        checks++; if (o_Valid1 !== 1'b1 || o_Fault1 !== 1'b1) begin errors++; $display("FAIL mis_half_store: got v=%b f=%b expected v=1 f=1", o_Valid1, o_Fault1); end
        checks++; if (o_RD1 !== 32'h0) begin errors++; $display("FAIL mis_store_rd1: got %h expected 00000000", o_RD1); end
        checks++; if (o_Valid2 !== 1'b1 || o_Fault2 !== 1'b1) begin errors++; $display("FAIL illegal_size: got v=%b f=%b expected v=1 f=1", o_Valid2, o_Fault2); end
        checks++; if (o_RD2 !== 32'h0) begin errors++; $display("FAIL illegal_rd2: got %h expected 00000000", o_RD2); end
        drive1(1'b0, 32'h30, 2'b10, 1'b0, 32'h0);
        drive2(1'b0, 32'h41, 2'b10, 1'b0, 32'h0);
        step();
        checks++; if (o_RD1 !== 32'h01020304 || o_Fault1 !== 1'b0) begin errors++; $display("FAIL mem_unchanged: got %h f=%b expected 01020304 f=0", o_RD1, o_Fault1); end
        checks++; if (o_Fault2 !== 1'b1) begin errors++; $display("FAIL mis_word_load: got f=%b expected 1", o_Fault2); end
    endtask

    task automatic test_hold();
        step();
        checks++; if (o_Valid1 !== 1'b0 || o_Fault1 !== 1'b0) begin errors++; $display("FAIL idle_flags: got v=%b f=%b expected v=0 f=0", o_Valid1, o_Fault1); end
        checks++; if (o_RD1 !== 32'h01020304) begin errors++; $display("FAIL idle_hold_rd1: got %h expected 01020304", o_RD1); end
    endtask

    task automatic test_wrap();
        drive1(1'b1, DEPTH + 32'h04, 2'b10, 1'b0, 32'hDEADBEEF);
        step();
        drive2(1'b0, 32'h04, 2'b10, 1'b0, 32'h0);
        step();
        checks++; if (o_RD2 !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_rd2: got %h expected deadbeef", o_RD2); end
        drive1(1'b1, 32'hFF, 2'b00, 1'b0, 32'h000000A5);
        step();
        drive1(1'b0, 32'hFF, 2'b00, 1'b1, 32'h0);
        step();
        checks++; if (o_RD1 !== 32'hFFFFFFA5) begin errors++; $display("FAIL last_byte: got %h expected ffffffa5", o_RD1); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
`ifdef DMEM_BYPASS_EN
        exp_same = 32'hCAFEF00D;
`else
        exp_same = 32'h00000000;
`endif
        drive1(1'b1, 32'h50, 2'b10, 1'b0, 32'hCAFEF00D);
        drive2(1'b0, 32'h50, 2'b10, 1'b0, 32'h0);
        step();
        checks++; if (o_RD2 !== exp_same) begin errors++; $display("FAIL same_cycle_ld: got %h expected %h", o_RD2, exp_same); end
        drive2(1'b0, 32'h50, 2'b10, 1'b0, 32'h0);
        step();
        checks++; if (o_RD2 !== 32'hCAFEF00D) begin errors++; $display("FAIL after_store_ld: got %h expected cafef00d", o_RD2); end
    endtask

    task automatic test_reset_mid();
        drive1(1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (o_Valid1 !== 1'b0 || o_RD1 !== 32'h0) begin errors++; $display("FAIL mid_reset: got v=%b rd=%h expected v=0 rd=00000000", o_Valid1, o_RD1); end
        idle();
        #2 rst_n = 1'b1;
        step();
        checks++; if (o_Valid1 !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got v=%b expected 0", o_Valid1); end
        drive1(1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
        drive2(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
        step();
        checks++; if (o_Valid1 !== 1'b1 || o_RD1 !== 32'h0) begin errors++; $display("FAIL post_reset_20: got v=%b rd=%h expected v=1 rd=00000000", o_Valid1, o_RD1); end
        checks++; if (o_RD2 !== 32'h0) begin errors++; $display("FAIL post_reset_40: got %h expected 00000000", o_RD2); end
        drive1(1'b0, 32'h04, 2'b10, 1'b0, 32'h0);
        drive2(1'b0, 32'hFF, 2'b00, 1'b0, 32'h0);
        step();
        checks++; if (o_RD1 !== 32'h0) begin errors++; $display("FAIL post_reset_04: got %h expected 00000000", o_RD1); end
        checks++; if (o_RD2 !== 32'h0) begin errors++; $display("FAIL post_reset_ff: got %h expected 00000000", o_RD2); end
        drive1(1'b0, 32'h50, 2'b10, 1'b0, 32'h0);
        drive2(1'b0, 32'h30, 2'b10, 1'b0, 32'h0);
        step();
        checks++; if (o_RD1 !== 32'h0 || o_RD2 !== 32'h0) begin errors++; $display("FAIL post_reset_50_30: got %h %h expected 00000000 00000000", o_RD1, o_RD2); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        i_Address1 = 32'h0; i_Address2 = 32'h0; i_Size1 = 2'b00; i_Size2 = 2'b00;
        i_Signed1 = 1'b0; i_Signed2 = 1'b0; i_WriteData1 = 32'h0; i_WriteData2 = 32'h0;
        test_reset();
        test_load_ext();
        test_collision();
        test_faults();
        test_hold();
        test_wrap();
        test_bypass();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
